// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Single-owner controller for the shared simulation memory
//               port. Arbitrates instruction fetch (IF) against load/store
//               (MEM), runs one transaction at a time with latched request
//               fields, and returns the 64-bit reply to the winner as a
//               one-cycle pulse. IF is protected from starvation and a dead
//               memory is cut off by a timeout that replies with err_o.
// Ports       : clk, rst (sync, active-low)
//               if_*   : IF read request / reply pulse + data
//               lsu_*  : MEM read/write request / reply pulse + data
//               err_o  : flags a reply produced by a timeout
//               busy_o : high whenever the FSM is not idle
//               mp_*   : shared memory port (request fields out, reply in)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rep_o,
  output logic [63:0] if_rep_data_o,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_write_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_rep_o,
  output logic [63:0] lsu_rep_data_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mp_req_o,
  output logic [31:0] mp_addr_o,
  output logic        mp_write_o,
  output logic [31:0] mp_wdata_o,
  output logic [3:0]  mp_wmask_o,
  input  logic        mp_rep_i,
  input  logic [63:0] mp_rep_data_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] c_to_last    = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_grant_if;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [31:0]      r_addr;
  logic             r_write;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic             r_if_rep;
  logic             r_lsu_rep;
  logic             r_err;
  logic [63:0]      r_if_data;
  logic [63:0]      r_lsu_data;

  logic             w_any_req;
  logic             w_pick_if;
  logic             w_to_hit;
  logic [63:0]      w_cap_data;

  assign w_any_req  = if_req_i | lsu_req_i;
  // MEM has priority unless IF has been passed over STARVE_LIMIT times.
  assign w_pick_if  = if_req_i & (~lsu_req_i | (r_starve_cnt == c_starve_lim));
  assign w_to_hit   = (r_to_cnt == c_to_last);
  // Writes never return data to the requester.
  assign w_cap_data = r_write ? 64'd0 : mp_rep_data_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_grant_if   <= 1'b0;
      r_starve_cnt <= '0;
      r_to_cnt     <= '0;
      r_addr       <= 32'd0;
      r_write      <= 1'b0;
      r_wdata      <= 32'd0;
      r_wmask      <= 4'd0;
      r_if_rep     <= 1'b0;
      r_lsu_rep    <= 1'b0;
      r_err        <= 1'b0;
      r_if_data    <= 64'd0;
      r_lsu_data   <= 64'd0;
    end else begin
      // Reply outputs are single-cycle pulses: cleared unless set below.
      r_if_rep   <= 1'b0;
      r_lsu_rep  <= 1'b0;
      r_err      <= 1'b0;
      r_if_data  <= 64'd0;
      r_lsu_data <= 64'd0;

      case (r_state)
        S_IDLE: begin
          if (!if_req_i) begin
            r_starve_cnt <= '0;
          end
          if (w_any_req) begin
            r_grant_if <= w_pick_if;
            r_to_cnt   <= '0;
            r_state    <= S_ISSUE;
            if (w_pick_if) begin
              r_addr       <= if_addr_i;
              r_write      <= 1'b0;
              r_wdata      <= 32'd0;
              r_wmask      <= 4'd0;
              r_starve_cnt <= '0;
            end else begin
              r_addr  <= lsu_addr_i;
              r_write <= lsu_write_i;
              r_wdata <= lsu_wdata_i;
              r_wmask <= lsu_wmask_i;
              if (if_req_i && (r_starve_cnt != c_starve_lim)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end
          end
        end

        S_ISSUE: begin
          // A completion on the threshold cycle still wins over the timeout.
          if (mp_rep_i) begin
            r_state    <= S_RESP;
            r_if_rep   <= r_grant_if;
            r_lsu_rep  <= ~r_grant_if;
            r_if_data  <= r_grant_if ? w_cap_data : 64'd0;
            r_lsu_data <= r_grant_if ? 64'd0 : w_cap_data;
          end else if (w_to_hit) begin
            r_state   <= S_RESP;
            r_if_rep  <= r_grant_if;
            r_lsu_rep <= ~r_grant_if;
            r_err     <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_rep_o       = r_if_rep;
  assign if_rep_data_o  = r_if_data;
  assign lsu_rep_o      = r_lsu_rep;
  assign lsu_rep_data_o = r_lsu_data;
  assign err_o          = r_err;
  assign busy_o         = (r_state != S_IDLE);
  assign mp_req_o       = (r_state == S_ISSUE);
  assign mp_addr_o      = r_addr;
  assign mp_write_o     = r_write;
  assign mp_wdata_o     = r_wdata;
  assign mp_wmask_o     = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. A small memory model
//               answers the port after a programmable delay; expected
//               replies are queued when requests are driven and compared
//               when a reply pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rep_o;
  logic [63:0] if_rep_data_o;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_write_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_wmask_i;
  logic        lsu_rep_o;
  logic [63:0] lsu_rep_data_o;
  logic        err_o;
  logic        busy_o;
  logic        mp_req_o;
  logic [31:0] mp_addr_o;
  logic        mp_write_o;
  logic [31:0] mp_wdata_o;
  logic [3:0]  mp_wmask_o;
  logic        mp_rep_i;
  logic [63:0] mp_rep_data_i;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rep_o(if_rep_o), .if_rep_data_o(if_rep_data_o),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_write_i(lsu_write_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
    .lsu_rep_o(lsu_rep_o), .lsu_rep_data_o(lsu_rep_data_o),
    .err_o(err_o), .busy_o(busy_o),
    .mp_req_o(mp_req_o), .mp_addr_o(mp_addr_o), .mp_write_o(mp_write_o),
    .mp_wdata_o(mp_wdata_o), .mp_wmask_o(mp_wmask_o),
    .mp_rep_i(mp_rep_i), .mp_rep_data_i(mp_rep_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_reps  = 0;

  typedef struct packed {
    logic        is_if;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 64'h1122334455667788;
    return {a ^ 32'hA5A5A5A5, a};
  endfunction

  function automatic exp_t mk(input logic is_if, input logic [63:0] d, input logic e);
    exp_t x;
    x.is_if = is_if;
    x.data  = d;
    x.err   = e;
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Memory model: answers mem_delay ISSUE cycles after the request appears.
  logic mem_on;
  int   mem_delay;
  int   wcnt;
  logic model_rep;
  logic force_rep;
  assign mp_rep_i = model_rep | force_rep;

  always @(negedge clk) begin
    if (mp_req_o !== 1'b1) begin
      wcnt      = 0;
      model_rep = 1'b0;
    end else begin
      model_rep = mem_on && (wcnt == mem_delay);
      wcnt      = wcnt + 1;
    end
    mp_rep_data_i = mem_val(mp_addr_o);
  end

  // Reply monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (if_rep_o === 1'b1 || lsu_rep_o === 1'b1)) begin
      n_reps = n_reps + 1;
      if (sb.size() == 0) begin
        check("unexpected_rep", {62'd0, if_rep_o, lsu_rep_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rep_if_pulse",  {63'd0, if_rep_o},  {63'd0, e.is_if});
        check("rep_lsu_pulse", {63'd0, lsu_rep_o}, {63'd0, ~e.is_if});
        check("rep_data", e.is_if ? if_rep_data_o : lsu_rep_data_o, e.data);
        check("rep_err",  {63'd0, err_o}, {63'd0, e.err});
        check("other_data_zero", e.is_if ? lsu_rep_data_o : if_rep_data_o, 64'd0);
      end
    end
  end

  task automatic wait_rep(input bit want_if, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (want_if ? (if_rep_o === 1'b1) : (lsu_rep_o === 1'b1)) seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int reps;
    int first_cyc;
    int last_cyc;
    int issue_cycles;
    int r0;

    rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0; lsu_req_i = 1'b0;
    lsu_addr_i = '0; lsu_write_i = 1'b0; lsu_wdata_i = '0; lsu_wmask_i = '0;
    mem_on = 1'b1; mem_delay = 0; force_rep = 1'b0; model_rep = 1'b0;
    mp_rep_data_i = '0; wcnt = 0;

    // Reset with both requests high, then first grant must go to MEM.
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h80;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h40;
    repeat (2) @(negedge clk);
    check("rst_busy",   {63'd0, busy_o},   64'd0);
    check("rst_mp_req", {63'd0, mp_req_o}, 64'd0);
    check("rst_reps",   {61'd0, if_rep_o, lsu_rep_o, err_o}, 64'd0);
    check("rst_mp_fields", {mp_addr_o, mp_wdata_o}, 64'd0);
    check("rst_mp_ctl", {59'd0, mp_write_o, mp_wmask_o}, 64'd0);
    sb.push_back(mk(1'b0, mem_val(32'h40), 1'b0));
    rst = 1'b1;
    @(negedge clk);
    check("first_grant_addr", {32'd0, mp_addr_o}, 64'h40);
    check("first_grant_req",  {63'd0, mp_req_o}, 64'd1);
    wait_rep(1'b0, 10, seen);
    check("first_grant_seen", {63'd0, seen}, 64'd1);
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk);
    check("idle_after_first", {63'd0, busy_o}, 64'd0);

    // Single IF read with zero-wait memory.
    if_req_i = 1'b1; if_addr_i = 32'h10;
    sb.push_back(mk(1'b1, 64'h1122334455667788, 1'b0));
    @(negedge clk);
    check("if_mp_req",  {63'd0, mp_req_o}, 64'd1);
    check("if_mp_addr", {32'd0, mp_addr_o}, 64'h10);
    check("if_mp_ctl",  {59'd0, mp_write_o, mp_wmask_o}, 64'd0);
    if_addr_i = 32'hFFFF0000;
    @(negedge clk);
    check("if_latency", {63'd0, if_rep_o}, 64'd1);
    check("if_resp_mp_req", {63'd0, mp_req_o}, 64'd0);
    if_req_i = 1'b0;
    @(negedge clk);
    check("if_pulse_one_cycle", {62'd0, if_rep_o, busy_o}, 64'd0);

    // MEM write: fields latched, reply data forced to 0.
    lsu_req_i = 1'b1; lsu_write_i = 1'b1; lsu_addr_i = 32'h24;
    lsu_wdata_i = 32'hDEADBEEF; lsu_wmask_i = 4'b1111;
    sb.push_back(mk(1'b0, 64'd0, 1'b0));
    @(negedge clk);
    check("wr_mp_addr",  {32'd0, mp_addr_o}, 64'h24);
    check("wr_mp_wdata", {32'd0, mp_wdata_o}, 64'hDEADBEEF);
    check("wr_mp_ctl",   {59'd0, mp_write_o, mp_wmask_o}, 64'h1F);
    lsu_wdata_i = 32'h0; lsu_wmask_i = 4'b0;
    @(negedge clk);
    check("wr_latency", {63'd0, lsu_rep_o}, 64'd1);
    lsu_req_i = 1'b0; lsu_write_i = 1'b0;
    @(negedge clk);

    // Completion strobe outside ISSUE must be ignored.
    force_rep = 1'b1;
    @(negedge clk);
    force_rep = 1'b0;
    check("stray_rep_busy", {61'd0, busy_o, if_rep_o, lsu_rep_o}, 64'd0);

    // Starvation: both requesters hold requests continuously.
    if_req_i = 1'b1; if_addr_i = 32'h50;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h30;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) sb.push_back(mk(1'b1, mem_val(32'h50), 1'b0));
      else        sb.push_back(mk(1'b0, mem_val(32'h30), 1'b0));
    end
    reps = 0; first_cyc = 0; last_cyc = 0;
    for (int c = 0; c < 40 && reps < 6; c++) begin
      @(negedge clk);
      if (if_rep_o === 1'b1 || lsu_rep_o === 1'b1) begin
        reps = reps + 1;
        if (reps == 1) first_cyc = c;
        last_cyc = c;
      end
    end
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    check("starve_rep_count", 64'(reps), 64'd6);
    check("throughput_3cyc", 64'(last_cyc - first_cyc), 64'd15);
    @(negedge clk);

    // Dead memory: ISSUE lasts TIMEOUT cycles then replies with err.
    mem_on = 1'b0;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h60;
    sb.push_back(mk(1'b0, 64'd0, 1'b1));
    issue_cycles = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (mp_req_o === 1'b1) issue_cycles = issue_cycles + 1;
      if (lsu_rep_o === 1'b1) seen = 1'b1;
    end
    lsu_req_i = 1'b0;
    check("timeout_seen", {63'd0, seen}, 64'd1);
    check("timeout_issue_len", 64'(issue_cycles), 64'd16);
    @(negedge clk);
    check("timeout_back_idle", {63'd0, busy_o}, 64'd0);
    mem_on = 1'b1;

    // Completion on the threshold cycle counts as success.
    mem_delay = 15;
    if_req_i = 1'b1; if_addr_i = 32'h70;
    sb.push_back(mk(1'b1, mem_val(32'h70), 1'b0));
    issue_cycles = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (mp_req_o === 1'b1) issue_cycles = issue_cycles + 1;
      if (if_rep_o === 1'b1) seen = 1'b1;
    end
    if_req_i = 1'b0;
    check("edge_seen", {63'd0, seen}, 64'd1);
    check("edge_issue_len", 64'(issue_cycles), 64'd16);
    @(negedge clk);
    mem_delay = 0;

    // Reset in the middle of ISSUE drops the transaction silently.
    mem_on = 1'b0;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h88;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", {63'd0, busy_o}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {62'd0, busy_o, mp_req_o}, 64'd0);
    check("midrst_addr_clr", {32'd0, mp_addr_o}, 64'd0);
    lsu_req_i = 1'b0; rst = 1'b1;
    r0 = n_reps;
    repeat (25) @(negedge clk);
    #1;
    check("midrst_no_rep", 64'(n_reps - r0), 64'd0);
    mem_on = 1'b1;

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-owner controller for the shared simulation memory port.
- Arbitrates between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Serialises one transaction at a time, holds request fields stable for the whole access, and returns the 64-bit reply to the winner as a one-cycle pulse.
- Adds starvation protection for IF and a timeout so a dead memory cannot hang the pipeline.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF is pending before IF is forced to win.
- TIMEOUT, 16: cycles in ISSUE without mem_rep_i before the transaction is aborted with error.
- CNT_W, 5: width of the internal starve and timeout counters; must hold max(STARVE_LIMIT, TIMEOUT).

Ports:
- clk  in  1  Single clock; all state updates on posedge.
- rst  in  1  Synchronous, active-low reset (sampled on posedge clk).
- if_req_i  in  1  IF read request; held high until if_rep_o seen.
- if_addr_i  in  32  IF byte address.
- if_rep_o  out  1  One-cycle reply pulse to IF.
- if_rep_data_o  out  64  Reply data; valid only with if_rep_o.
- lsu_req_i  in  1  MEM request; held high until lsu_rep_o seen.
- lsu_addr_i  in  32  MEM byte address.
- lsu_write_i  in  1  1 = write, 0 = read.
- lsu_wdata_i  in  32  Write data.
- lsu_wmask_i  in  4  Byte write mask.
- lsu_rep_o  out  1  One-cycle reply pulse to MEM.
- lsu_rep_data_o  out  64  Read data; 0 for writes.
- err_o  out  1  Pulses with a rep_o when that transaction timed out.
- busy_o  out  1  High whenever state is not IDLE.
- mp_req_o  out  1  Memory port request.
- mp_addr_o  out  32  Latched address.
- mp_write_o  out  1  Latched write strobe.
- mp_wdata_o  out  32  Latched write data.
- mp_wmask_o  out  4  Latched mask.
- mp_rep_i  in  1  Memory completion; valid for reads and writes.
- mp_rep_data_i  in  64  Memory read data.

Behaviour:
- Reset (rst=0 at posedge):
  - State goes to IDLE; the grant register clears.
  - Starve and timeout counters go to 0; the latched fields go to 0.
  - All outputs are 0.
  - Any in-flight transaction is dropped with no reply pulse.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its addr/write/wdata/wmask (IF latches write=0, mask=0), clear the timeout counter, go to ISSUE.
- Grant rule:
  - Only lsu_req_i: MEM wins. Only if_req_i: IF wins.
  - Both asserted: MEM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- Starve counter:
  - Increments on each MEM grant made while if_req_i=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant, or in any IDLE cycle where if_req_i=0.
- ISSUE:
  - mp_req_o=1 and the mp_* fields show the latched values every cycle.
  - mp_rep_i=1: capture mp_rep_data_i (captured as 0 for writes), go to RESP with err=0.
  - Else the timeout counter increments. When it reaches TIMEOUT-1 without mp_rep_i, capture data 0, go to RESP with err=1.
  - mp_rep_i in the same cycle as the timeout threshold counts as success.
- RESP:
  - mp_req_o=0.
  - Exactly one of if_rep_o/lsu_rep_o is 1, according to the grant, with its data and err_o.
  - Go to IDLE next cycle. The non-granted rep_o and data stay 0.
- Requester contract:
  - Drop req_i in the cycle after seeing rep_o. The arbiter samples requests again only in IDLE.
  - A req_i still high in that IDLE cycle is treated as a new request.
- Latency:
  - Request visible in IDLE cycle N, with zero-wait memory (mp_rep_i in ISSUE cycle N+1): rep_o in cycle N+2.
  - Back-to-back throughput: one transaction per 3 cycles.
- Stability:
  - Changes on *_addr_i/wdata during ISSUE/RESP are ignored; the latched values are used.
  - mp_rep_i outside ISSUE is ignored.
- Widths: mp_rep_data_i is passed through unmodified as 64 bits; no byte selection in this block.

Test Plan:
- Reset: rst=0 for 2 cycles while both reqs are high -> all outputs 0 and busy_o=0. After release with both reqs still high, the first grant goes to MEM.
- Single IF read: if_addr_i=0x10, memory returns 0x1122334455667788 the same cycle -> mp_req_o high one cycle with mp_addr_o=0x10. if_rep_o pulses 2 cycles after the request with that data, err_o=0.
- MEM write: lsu_write_i=1, addr=0x24, wdata=0xDEADBEEF, mask=4'b1111 -> mp_write_o=1 with the fields latched. lsu_rep_o pulses with data 0.
- Starvation: both reqs continuously high, MEM re-requests after every reply -> grant order MEM,MEM,MEM,MEM,IF,MEM… (IF served after exactly 4 MEM grants with STARVE_LIMIT=4).
- Timeout: mp_rep_i held 0 -> ISSUE lasts 16 cycles, then the granted rep_o pulses with err_o=1 and data 0. The FSM returns to IDLE.
- Mid-operation reset: rst=0 during ISSUE -> next cycle IDLE, mp_req_o=0, and no rep_o pulse ever issued for that transaction.
